module_spi_shift_engine: RTL and testbench
==========================================

# module_spi_shift_engine

Parametrised full-duplex SPI master shift engine for the SPI interface. It generates SCLK from the system clock, drives MOSI and CS_n, and samples MISO. Bit order and all four CPOL/CPHA modes are selectable per transfer. It sits between the register/control layer, which supplies the word and a start pulse, and the SPI pins. It returns the received word with a one-cycle done pulse.

## Interface
- DATA_WIDTH, 8: bits per transfer; must be ≥ 2.
- CLK_DIV, 4: clk_i cycles per SCLK half-period; must be ≥ 2.

- clk_i  input  1  system clock; all logic on its rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  transfer request; accepted only in a cycle where busy_o=0.
- cpol_i  input  1  SCLK idle level; latched on accept.
- cpha_i  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on accept.
- lsb_first_i  input  1  1 = LSB first on both MOSI and MISO; latched on accept.
- tx_data_i  input  DATA_WIDTH  word to send; latched on accept.
- miso_i  input  1  serial data from the slave.
- sclk_o  output  1  SPI clock; registered.
- mosi_o  output  1  serial data to the slave; registered.
- cs_n_o  output  1  chip select, active-low; registered.
- rx_data_o  output  DATA_WIDTH  last received word; held until the next done.
- busy_o  output  1  high from the cycle after accept until the done cycle (exclusive).
- done_o  output  1  one-cycle pulse at transfer end.

## Operation
- States:
  - IDLE: cs_n_o=1, mosi_o=0, busy_o=0. sclk_o is loaded with cpol_i every cycle, so it tracks the idle level with one cycle of lag.
  - LEAD: CS setup, CLK_DIV cycles, sclk_o at the idle level.
  - XFER: 2·DATA_WIDTH SCLK edges, one every CLK_DIV cycles.
  - TRAIL: CS hold, CLK_DIV cycles, sclk_o back at the idle level.
- Transitions: IDLE→LEAD on start_i. LEAD→XFER and XFER→TRAIL when the half-period counter expires. TRAIL→IDLE on expiry.
- Edges are numbered 1..2W with W = DATA_WIDTH. Odd edges are leading edges (away from CPOL), even edges are trailing edges.
- CPHA=0:
  - First bit is on mosi_o from LEAD entry.
  - miso_i is sampled on odd edges.
  - mosi_o advances on even edges 2..2W-2.
- CPHA=1:
  - mosi_o=0 in LEAD.
  - First bit is driven at edge 1; mosi_o advances on odd edges 3..2W-1.
  - miso_i is sampled on even edges.
- Bit order: lsb_first=0 sends tx[W-1] first, and the first received bit lands in rx[W-1]. lsb_first=1 mirrors this.
- mosi_o holds its last bit through TRAIL and returns to 0 in IDLE.
- rx_data_o is written with the assembled word in the done cycle only.
- start_i while busy_o=1 is ignored. Changes on cpol_i, cpha_i, lsb_first_i or tx_data_i mid-transfer have no effect.
- Reset, at any time including mid-transfer, forces:
  - state IDLE; sclk_o, mosi_o, busy_o, done_o and rx_data_o to 0; cs_n_o to 1.
  - No done_o pulse for the aborted transfer.

## Timing
- start_i sampled high at edge k:
  - cs_n_o=0 and busy_o=1 from k+1.
  - SCLK edge n occurs at k+1+n·CLK_DIV.
  - cs_n_o=1, busy_o=0 and done_o=1 at k+1+(2W+1)·CLK_DIV, with rx_data_o valid in the same cycle.
- Defaults (W=8, CLK_DIV=4): done at k+69; SCLK period 8 clk_i cycles.
- The done cycle is IDLE, so a start_i in that cycle is accepted. This gives back-to-back transfers with a single-cycle CS_n high gap.
- MISO is sampled in the same clk_i cycle in which sclk_o toggles.
- The half-period counter is $clog2(CLK_DIV) bits wide. The bit counter is $clog2(2·DATA_WIDTH+1) bits wide.

## Test plan
- Reset → cs_n_o=1, sclk_o=0, mosi_o=0, busy_o=0, done_o=0, rx_data_o=0x00.
- Mode 0, MSB first, tx=0xA5, miso tied to mosi → mosi sequence 1,0,1,0,0,1,0,1; 16 SCLK edges; done_o at k+69; rx_data_o=0xA5.
- Mode 3, LSB first, tx=0x3C, slave model returns 0x81 LSB first, changing on leading edges → sclk idles high; mosi sequence 0,0,1,1,1,1,0,0; rx_data_o=0x81.
- Modes 1 and 2 with a slave model returning 0x5A MSB first → rx_data_o=0x5A. Sampling must occur on the edges specified for each mode.
- start_i pulsed mid-transfer with tx=0xFF → ignored, exactly one done_o. Then start_i with 0x0F in the done cycle → accepted; cs_n_o high for exactly one cycle; 0x0F sent.
- rst_i asserted between edges 5 and 6 → outputs at reset values immediately, no done_o. A following transfer of 0xC3 completes normally.

Source files
------------

// File: rtl/module_spi_shift_engine.sv
// Full-duplex SPI master shift engine: generates SCLK, drives MOSI/CS_n, samples MISO.
// Supports all four CPOL/CPHA modes and MSB/LSB-first order, selected per transfer.
module module_spi_shift_engine #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  lsb_first_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  miso_i,
    output logic                  sclk_o,
    output logic                  mosi_o,
    output logic                  cs_n_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam int unsigned EW = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [EW-1:0]         edge_q, edge_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic                  lsb_q, lsb_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_n_q, cs_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] tx_oriented;
    logic [EW-1:0]         edge_n;
    logic                  expired;
    logic                  sample_edge;
    logic                  drive_edge;

    // Bit reversal used to map LSB-first order onto the MSB-first shifters.
    function automatic logic [DATA_WIDTH-1:0] reverse_bits(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            r[i] = w[DATA_WIDTH-1-i];
        end
        return r;
    endfunction

    // Edge decode: number of the edge about to be produced and its role in the current mode.
    assign tx_oriented = lsb_first_i ? reverse_bits(tx_data_i) : tx_data_i;
    assign edge_n      = edge_q + EW'(1);
    assign expired     = (cnt_q == CNT_MAX);
    assign sample_edge = cpha_q ? ~edge_n[0] : edge_n[0];
    assign drive_edge  = cpha_q ? edge_n[0] : (~edge_n[0] && (edge_n != EDGE_LAST));

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                sclk_d = cpol_i;
                mosi_d = 1'b0;
                cs_n_d = 1'b1;
                busy_d = 1'b0;
                if (start_i) begin
                    state_d = LEAD;
                    cnt_d   = '0;
                    edge_d  = '0;
                    cpol_d  = cpol_i;
                    cpha_d  = cpha_i;
                    lsb_d   = lsb_first_i;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    rx_sh_d = '0;
                    if (cpha_i) begin
                        tx_sh_d = tx_oriented;
                        mosi_d  = 1'b0;
                    end else begin
                        mosi_d  = tx_oriented[DATA_WIDTH-1];
                        tx_sh_d = tx_oriented << 1;
                    end
                end
            end
            LEAD, XFER: begin
                cnt_d = cnt_q + CW'(1);
                if (state_q == LEAD) begin
                    sclk_d = cpol_q;
                end
                if (expired) begin
                    cnt_d  = '0;
                    edge_d = edge_n;
                    sclk_d = ~sclk_q;
                    if (sample_edge) begin
                        rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], miso_i};
                    end
                    if (drive_edge) begin
                        mosi_d  = tx_sh_q[DATA_WIDTH-1];
                        tx_sh_d = tx_sh_q << 1;
                    end
                    state_d = (edge_n == EDGE_LAST) ? TRAIL : XFER;
                end
            end
            TRAIL: begin
                cnt_d = cnt_q + CW'(1);
                if (expired) begin
                    cnt_d     = '0;
                    state_d   = IDLE;
                    sclk_d    = cpol_q;
                    mosi_d    = 1'b0;
                    cs_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = lsb_q ? reverse_bits(rx_sh_q) : rx_sh_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            edge_q    <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign cs_n_o    = cs_n_q;
    assign rx_data_o = rx_data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_module_spi_shift_engine.sv
// Bench for the SPI shift engine: a behavioural SPI slave exchanges words with the DUT
// and each scenario task compares the observed transfer against the expected one.
module tb_module_spi_shift_engine;

    localparam int W  = 8;
    localparam int CD = 4;
    localparam int DONE_T = 1 + (2 * W + 1) * CD;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i, cpol_i, cpha_i, lsb_first_i, miso_i;
    logic [W-1:0] tx_data_i;
    logic         sclk_o, mosi_o, cs_n_o, busy_o, done_o;
    logic [W-1:0] rx_data_o;

    int tests_run    = 0;
    int tests_failed = 0;

    // Observations from the most recent transfer.
    logic         obs_csn1, obs_busy1, obs_sclk1, obs_mosi1;
    int           obs_edges;
    int           obs_edge_t [1:2*W];
    logic [W-1:0] obs_mosi_word, obs_rx;
    int           obs_done_t;
    logic         obs_done_csn, obs_done_busy;
    bit           obs_timeout, obs_rx_early;

    always #5 clk_i = ~clk_i;

    module_spi_shift_engine #(.DATA_WIDTH(W), .CLK_DIV(CD)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .cpol_i(cpol_i),
        .cpha_i(cpha_i), .lsb_first_i(lsb_first_i), .tx_data_i(tx_data_i),
        .miso_i(miso_i), .sclk_o(sclk_o), .mosi_o(mosi_o), .cs_n_o(cs_n_o),
        .rx_data_o(rx_data_o), .busy_o(busy_o), .done_o(done_o)
    );

    function automatic logic slv_bit(input logic [W-1:0] w, input logic lsb, input int i);
        return lsb ? w[i] : w[W-1-i];
    endfunction

    // Starts a transfer and plays the slave: it presents bits of sw on its shift edges and
    // captures MOSI on its sample edges. Returns at the done sample (or at edge stop_edge).
    task automatic xfer(input logic cpol, input logic cpha, input logic lsb,
                        input logic [W-1:0] tx, input logic [W-1:0] sw,
                        input int stop_edge, input bit mid_start);
        int sidx = 0;
        int midx = 0;
        logic prev_sclk = cpol;
        logic prev_mosi = 1'b0;
        logic lead;
        logic [W-1:0] rx_before = rx_data_o;
        cpol_i = cpol; cpha_i = cpha; lsb_first_i = lsb; tx_data_i = tx; start_i = 1'b1;
        miso_i = 1'b0;
        obs_edges = 0; obs_mosi_word = '0; obs_rx = '0; obs_done_t = -1;
        obs_timeout = 0; obs_rx_early = 0; obs_done_csn = 1'bx; obs_done_busy = 1'bx;
        for (int n = 1; n <= 2 * W; n++) obs_edge_t[n] = -1;
        for (int t = 1; t <= 200; t++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            if (t == 1) begin
                obs_csn1 = cs_n_o; obs_busy1 = busy_o; obs_sclk1 = sclk_o; obs_mosi1 = mosi_o;
                if (!cpha) begin
                    miso_i = slv_bit(sw, lsb, 0);
                    sidx = 1;
                end
            end else if (sclk_o !== prev_sclk) begin
                obs_edges++;
                if (obs_edges <= 2 * W) obs_edge_t[obs_edges] = t;
                lead = (sclk_o != cpol);
                if ((cpha == 1'b0) == lead) begin
                    if (midx < W) begin
                        if (lsb) obs_mosi_word[midx] = prev_mosi;
                        else     obs_mosi_word[W-1-midx] = prev_mosi;
                        midx++;
                    end
                end else if (sidx < W) begin
                    miso_i = slv_bit(sw, lsb, sidx);
                    sidx++;
                end
            end
            if (mid_start && t == 1 + 3 * CD) begin
                start_i = 1'b1; tx_data_i = '1;
                cpol_i = ~cpol; cpha_i = ~cpha; lsb_first_i = ~lsb;
            end
            if (done_o === 1'b1) begin
                obs_done_t = t; obs_rx = rx_data_o;
                obs_done_csn = cs_n_o; obs_done_busy = busy_o;
                miso_i = 1'b0;
                return;
            end
            if (rx_data_o !== rx_before) obs_rx_early = 1;
            if (stop_edge != 0 && obs_edges == stop_edge) return;
            prev_sclk = sclk_o;
            prev_mosi = mosi_o;
        end
        obs_timeout = 1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; start_i = 0; cpol_i = 0; cpha_i = 0; lsb_first_i = 0;
        tx_data_i = '0; miso_i = 0;
        repeat (3) @(posedge clk_i);
        #1;
        tests_run++; if (cs_n_o !== 1'b1) begin tests_failed++; $display("FAIL reset_cs_n: got %b want 1", cs_n_o); end
        tests_run++; if (sclk_o !== 1'b0) begin tests_failed++; $display("FAIL reset_sclk: got %b want 0", sclk_o); end
        tests_run++; if (mosi_o !== 1'b0) begin tests_failed++; $display("FAIL reset_mosi: got %b want 0", mosi_o); end
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        tests_run++; if (done_o !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done_o); end
        tests_run++; if (rx_data_o !== 8'h00) begin tests_failed++; $display("FAIL reset_rx: got %h want 00", rx_data_o); end
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic test_mode0_msb();
        int errs = 0;
        xfer(1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5, 0, 0);
        for (int n = 1; n <= 2 * W; n++) if (obs_edge_t[n] != 1 + n * CD) errs++;
        tests_run++; if (obs_timeout) begin tests_failed++; $display("FAIL m0_timeout: no done within budget"); end
        tests_run++; if (obs_csn1 !== 1'b0 || obs_busy1 !== 1'b1) begin tests_failed++; $display("FAIL m0_accept: cs_n=%b busy=%b want 0/1", obs_csn1, obs_busy1); end
        tests_run++; if (obs_mosi1 !== 1'b1) begin tests_failed++; $display("FAIL m0_first_bit: got %b want 1", obs_mosi1); end
        tests_run++; if (obs_edges != 2 * W) begin tests_failed++; $display("FAIL m0_edges: got %0d want %0d", obs_edges, 2 * W); end
        tests_run++; if (errs != 0) begin tests_failed++; $display("FAIL m0_edge_timing: %0d misplaced edges want 0", errs); end
        tests_run++; if (obs_done_t != DONE_T) begin tests_failed++; $display("FAIL m0_done_time: got %0d want %0d", obs_done_t, DONE_T); end
        tests_run++; if (obs_done_csn !== 1'b1 || obs_done_busy !== 1'b0) begin tests_failed++; $display("FAIL m0_done_flags: cs_n=%b busy=%b want 1/0", obs_done_csn, obs_done_busy); end
        tests_run++; if (obs_mosi_word !== 8'hA5) begin tests_failed++; $display("FAIL m0_mosi: got %h want a5", obs_mosi_word); end
        tests_run++; if (obs_rx !== 8'hA5) begin tests_failed++; $display("FAIL m0_rx: got %h want a5", obs_rx); end
        tests_run++; if (obs_rx_early) begin tests_failed++; $display("FAIL m0_rx_hold: rx_data_o changed before done"); end
        @(posedge clk_i); #1;
        tests_run++; if (mosi_o !== 1'b0) begin tests_failed++; $display("FAIL m0_idle_mosi: got %b want 0", mosi_o); end
    endtask

    task automatic test_mode3_lsb();
        xfer(1'b1, 1'b1, 1'b1, 8'h3C, 8'h81, 0, 0);
        tests_run++; if (obs_sclk1 !== 1'b1) begin tests_failed++; $display("FAIL m3_sclk_idle: got %b want 1", obs_sclk1); end
        tests_run++; if (obs_mosi1 !== 1'b0) begin tests_failed++; $display("FAIL m3_lead_mosi: got %b want 0", obs_mosi1); end
        tests_run++; if (obs_edges != 2 * W) begin tests_failed++; $display("FAIL m3_edges: got %0d want %0d", obs_edges, 2 * W); end
        tests_run++; if (obs_mosi_word !== 8'h3C) begin tests_failed++; $display("FAIL m3_mosi: got %h want 3c", obs_mosi_word); end
        tests_run++; if (obs_rx !== 8'h81) begin tests_failed++; $display("FAIL m3_rx: got %h want 81", obs_rx); end
        tests_run++; if (obs_done_t != DONE_T) begin tests_failed++; $display("FAIL m3_done_time: got %0d want %0d", obs_done_t, DONE_T); end
    endtask

    task automatic test_modes12();
        logic [W-1:0] tx = W'($urandom);
        xfer(1'b0, 1'b1, 1'b0, tx, 8'h5A, 0, 0);
        tests_run++; if (obs_mosi1 !== 1'b0) begin tests_failed++; $display("FAIL m1_lead_mosi: got %b want 0", obs_mosi1); end
        tests_run++; if (obs_rx !== 8'h5A) begin tests_failed++; $display("FAIL m1_rx: got %h want 5a", obs_rx); end
        tests_run++; if (obs_mosi_word !== tx) begin tests_failed++; $display("FAIL m1_mosi: got %h want %h", obs_mosi_word, tx); end
        tx = W'($urandom);
        xfer(1'b1, 1'b0, 1'b0, tx, 8'h5A, 0, 0);
        tests_run++; if (obs_sclk1 !== 1'b1) begin tests_failed++; $display("FAIL m2_sclk_idle: got %b want 1", obs_sclk1); end
        tests_run++; if (obs_rx !== 8'h5A) begin tests_failed++; $display("FAIL m2_rx: got %h want 5a", obs_rx); end
        tests_run++; if (obs_mosi_word !== tx) begin tests_failed++; $display("FAIL m2_mosi: got %h want %h", obs_mosi_word, tx); end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        logic [W-1:0] sw = W'($urandom);
        xfer(1'b0, 1'b0, 1'b0, 8'h33, 8'hC6, 0, 1);
        tests_run++; if (obs_done_t != DONE_T) begin tests_failed++; $display("FAIL b2b_ignored_start: done at %0d want %0d", obs_done_t, DONE_T); end
        tests_run++; if (obs_mosi_word !== 8'h33) begin tests_failed++; $display("FAIL b2b_first_mosi: got %h want 33", obs_mosi_word); end
        tests_run++; if (obs_rx !== 8'hC6) begin tests_failed++; $display("FAIL b2b_first_rx: got %h want c6", obs_rx); end
        tests_run++; if (obs_done_csn !== 1'b1) begin tests_failed++; $display("FAIL b2b_gap_high: cs_n=%b want 1", obs_done_csn); end
        xfer(1'b0, 1'b0, 1'b0, 8'h0F, sw, 0, 0);
        tests_run++; if (obs_csn1 !== 1'b0) begin tests_failed++; $display("FAIL b2b_gap_one_cycle: cs_n=%b want 0", obs_csn1); end
        tests_run++; if (obs_mosi_word !== 8'h0F) begin tests_failed++; $display("FAIL b2b_second_mosi: got %h want 0f", obs_mosi_word); end
        tests_run++; if (obs_rx !== sw) begin tests_failed++; $display("FAIL b2b_second_rx: got %h want %h", obs_rx, sw); end
        tests_run++; if (obs_done_t != DONE_T) begin tests_failed++; $display("FAIL b2b_second_done: got %0d want %0d", obs_done_t, DONE_T); end
        repeat (100) begin
            @(posedge clk_i); #1;
            if (done_o === 1'b1) dones++;
        end
        tests_run++; if (dones != 0) begin tests_failed++; $display("FAIL b2b_extra_done: got %0d want 0", dones); end
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        int csn_low = 0;
        logic [W-1:0] sw = W'($urandom);
        xfer(1'b0, 1'b0, 1'b0, 8'h96, 8'h69, 5, 0);
        tests_run++; if (obs_edges != 5) begin tests_failed++; $display("FAIL abort_reach_edge5: got %0d edges want 5", obs_edges); end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        #1;
        tests_run++; if ({sclk_o, mosi_o, cs_n_o, busy_o, done_o} !== 5'b00100) begin tests_failed++; $display("FAIL abort_outputs: sclk,mosi,cs_n,busy,done=%b want 00100", {sclk_o, mosi_o, cs_n_o, busy_o, done_o}); end
        tests_run++; if (rx_data_o !== 8'h00) begin tests_failed++; $display("FAIL abort_rx: got %h want 00", rx_data_o); end
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        repeat (80) begin
            @(posedge clk_i); #1;
            if (done_o === 1'b1) dones++;
            if (cs_n_o !== 1'b1) csn_low++;
        end
        tests_run++; if (dones != 0) begin tests_failed++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
        tests_run++; if (csn_low != 0) begin tests_failed++; $display("FAIL abort_cs_idle: cs_n low %0d cycles want 0", csn_low); end
        xfer(1'b0, 1'b0, 1'b0, 8'hC3, sw, 0, 0);
        tests_run++; if (obs_mosi_word !== 8'hC3) begin tests_failed++; $display("FAIL abort_next_mosi: got %h want c3", obs_mosi_word); end
        tests_run++; if (obs_rx !== sw) begin tests_failed++; $display("FAIL abort_next_rx: got %h want %h", obs_rx, sw); end
        tests_run++; if (obs_done_t != DONE_T) begin tests_failed++; $display("FAIL abort_next_done: got %0d want %0d", obs_done_t, DONE_T); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic cpol = 1'($urandom);
            logic cpha = 1'($urandom);
            logic lsb  = 1'($urandom);
            logic [W-1:0] tx = W'($urandom);
            logic [W-1:0] sw = W'($urandom);
            int errs = 0;
            xfer(cpol, cpha, lsb, tx, sw, 0, 0);
            for (int n = 1; n <= 2 * W; n++) if (obs_edge_t[n] != 1 + n * CD) errs++;
            tests_run++; if (obs_mosi_word !== tx) begin tests_failed++; $display("FAIL rand%0d_mosi: mode %b%b lsb %b got %h want %h", i, cpol, cpha, lsb, obs_mosi_word, tx); end
            tests_run++; if (obs_rx !== sw) begin tests_failed++; $display("FAIL rand%0d_rx: mode %b%b lsb %b got %h want %h", i, cpol, cpha, lsb, obs_rx, sw); end
            tests_run++; if (errs != 0 || obs_edges != 2 * W) begin tests_failed++; $display("FAIL rand%0d_edges: %0d edges, %0d misplaced, want %0d/0", i, obs_edges, errs, 2 * W); end
            tests_run++; if (obs_done_t != DONE_T) begin tests_failed++; $display("FAIL rand%0d_done: got %0d want %0d", i, obs_done_t, DONE_T); end
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        test_reset();
        test_mode0_msb();
        test_mode3_lsb();
        test_modes12();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
